array_feeder: RTL and testbench

// Producer side of the 4x4 systolic array: buffers one A-matrix and one B-matrix

---
 rtl/array_feeder_pkg.sv | 19 +
 rtl/array_feeder_if.sv | 29 ++
 rtl/array_feeder_skew_select.sv | 25 ++
 rtl/array_feeder.sv | 135 +++++++++++++
 tb/tb_array_feeder.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/array_feeder_pkg.sv
// Shared constants and state encoding for the systolic-array feeder.
package array_feeder_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_N          = 4;
  localparam int ACC_WIDTH      = 32;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } feeder_state_e;

  // Stream counter must hold 0..3N-2.
  function automatic int stream_cnt_width(input int n);
    return $clog2(3 * n - 1);
  endfunction

endpackage

// File: rtl/array_feeder_if.sv
// Load handshake plus array-facing stream bus of the feeder.
interface array_feeder_if
  import array_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N
);

  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] in_a_col;
  logic [N*DATA_WIDTH-1:0] in_b_row;
  logic                    arr_we;
  logic [N*DATA_WIDTH-1:0] arr_a;
  logic [N*DATA_WIDTH-1:0] arr_b;
  logic                    busy;
  logic                    done;

  modport master (
    output in_valid, in_a_col, in_b_row,
    input  in_ready, arr_we, arr_a, arr_b, busy, done
  );

  modport slave (
    input  in_valid, in_a_col, in_b_row,
    output in_ready, arr_we, arr_a, arr_b, busy, done
  );

endinterface

// File: rtl/array_feeder_skew_select.sv
// Picks element t-LANE of an N-entry lane buffer, or zero outside the skewed window.
module skew_select
  import array_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N,
  parameter int LANE       = 0,
  parameter int CNT_W      = stream_cnt_width(DEF_N)
) (
  input  logic [CNT_W-1:0]        t,
  input  logic [N*DATA_WIDTH-1:0] lane_buf,
  output logic [DATA_WIDTH-1:0]   elem
);

  // Matching t against LANE+s avoids a signed subtraction on the counter.
  always_comb begin
    elem = '0;
    for (int s = 0; s < N; s++) begin
      if (t == CNT_W'(LANE + s)) begin
        elem = lane_buf[s*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/array_feeder.sv
// Buffers one A and one B tile, then streams them diagonally skewed into a
// systolic array and flags when the last products have reached the far PE.
module array_feeder
  import array_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N
) (
  input  logic         clk,
  input  logic         rst_n,
  array_feeder_if.slave bus
);

  localparam int                CNT_W     = stream_cnt_width(N);
  localparam int                BEAT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0]  T_LAST    = CNT_W'(3 * N - 3);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(N - 1);

  feeder_state_e state;
  feeder_state_e state_nxt;

  logic [BEAT_W-1:0]       beat_cnt;
  logic [CNT_W-1:0]        t_cnt;
  logic                    ready_en;
  logic                    accept;
  logic                    last_beat;

  logic [N*DATA_WIDTH-1:0] a_buf  [N];
  logic [N*DATA_WIDTH-1:0] b_buf  [N];
  logic [N*DATA_WIDTH-1:0] a_lane [N];
  logic [N*DATA_WIDTH-1:0] b_lane [N];
  logic [N*DATA_WIDTH-1:0] a_skew;
  logic [N*DATA_WIDTH-1:0] b_skew;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_beat = accept && (beat_cnt == BEAT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_LOAD:   if (last_beat) state_nxt = ST_STREAM;
      ST_STREAM: if (t_cnt == T_LAST) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_LOAD;
      default:   state_nxt = ST_LOAD;
    endcase
  end

  // ready_en keeps in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      t_cnt    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
      if (state == ST_STREAM && t_cnt != T_LAST) begin
        t_cnt <= t_cnt + 1'b1;
      end else begin
        t_cnt <= '0;
      end
    end
  end

  // Tile storage is deliberately not reset; stale contents are never streamed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_buf[beat_cnt] <= bus.in_a_col;
      b_buf[beat_cnt] <= bus.in_b_row;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    for (genvar k = 0; k < N; k++) begin : g_slot
      assign a_lane[i][k*DATA_WIDTH +: DATA_WIDTH] = a_buf[k][i*DATA_WIDTH +: DATA_WIDTH];
      assign b_lane[i][k*DATA_WIDTH +: DATA_WIDTH] = b_buf[k][i*DATA_WIDTH +: DATA_WIDTH];
    end

    skew_select #(
      .DATA_WIDTH (DATA_WIDTH),
      .N          (N),
      .LANE       (i),
      .CNT_W      (CNT_W)
    ) u_row_a (
      .t        (t_cnt),
      .lane_buf (a_lane[i]),
      .elem     (a_skew[i*DATA_WIDTH +: DATA_WIDTH])
    );

    skew_select #(
      .DATA_WIDTH (DATA_WIDTH),
      .N          (N),
      .LANE       (i),
      .CNT_W      (CNT_W)
    ) u_col_b (
      .t        (t_cnt),
      .lane_buf (b_lane[i]),
      .elem     (b_skew[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.arr_we   = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.arr_a    = '0;
    bus.arr_b    = '0;
    unique case (state)
      ST_LOAD: bus.in_ready = ready_en;
      ST_STREAM: begin
        bus.arr_we = 1'b1;
        bus.busy   = 1'b1;
        bus.arr_a  = a_skew;
        bus.arr_b  = b_skew;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        bus.busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_array_feeder.sv
// Self-checking bench: table of tiles checked against skew rules and a matrix-product model.
module tb_array_feeder;
  import array_feeder_pkg::*;

  localparam int DW       = 8;
  localparam int N        = 4;
  localparam int T_STREAM = 3 * N - 2;

  typedef struct {
    int          tile_kind;
    bit          toggle;
    bit          hold_valid;
    int          exp_load_cycles;
    bit          has_corner;
    logic [31:0] exp_c33;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  array_feeder_if #(.DATA_WIDTH(DW), .N(N)) bus ();

  array_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]   mat_a  [N][N];
  logic [DW-1:0]   mat_b  [N][N];
  logic [N*DW-1:0] seen_a [T_STREAM];
  logic [N*DW-1:0] seen_b [T_STREAM];
  vec_t            vecs   [5];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic fill_tile(input int kind);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        case (kind)
          0: begin
            mat_a[i][j] = (i == j) ? 8'd1 : 8'd0;
            mat_b[i][j] = 8'(i * 4 + j + 1);
          end
          1: begin
            mat_a[i][j] = 8'h02;
            mat_b[i][j] = 8'h03;
          end
          2: begin
            mat_a[i][j] = 8'hFF;
            mat_b[i][j] = 8'hFF;
          end
          default: begin
            mat_a[i][j] = 8'($urandom);
            mat_b[i][j] = 8'($urandom);
          end
        endcase
      end
    end
  endtask

  task automatic drive_garbage(input logic valid);
    bus.in_valid = valid;
    bus.in_a_col = (N*DW)'($urandom);
    bus.in_b_row = (N*DW)'($urandom);
  endtask

  // Presents the current tile one beat at a time; returns cycles used to land all beats.
  task automatic applyStimulus(input bit toggle, output int cycles);
    int   k;
    int   cyc;
    logic v;
    k   = 0;
    cyc = 0;
    while (k < N && cyc < 50) begin
      @(negedge clk);
      v = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (v) begin
        bus.in_valid = 1'b1;
        for (int r = 0; r < N; r++) begin
          bus.in_a_col[r*DW +: DW] = mat_a[r][k];
          bus.in_b_row[r*DW +: DW] = mat_b[k][r];
        end
      end else begin
        drive_garbage(1'b0);
      end
      if (v && bus.in_ready) k++;
      cyc++;
    end
    cycles = cyc;
  endtask

  task automatic runStream(input bit hold_valid);
    logic [N*DW-1:0] ea;
    logic [N*DW-1:0] eb;
    for (int t = 0; t < T_STREAM; t++) begin
      @(negedge clk);
      ea = '0;
      eb = '0;
      for (int l = 0; l < N; l++) begin
        if (t - l >= 0 && t - l < N) begin
          ea[l*DW +: DW] = mat_a[l][t-l];
          eb[l*DW +: DW] = mat_b[t-l][l];
        end
      end
      seen_a[t] = bus.arr_a;
      seen_b[t] = bus.arr_b;
      checkOutput($sformatf("stream t%0d arr_a", t), 64'(bus.arr_a), 64'(ea));
      checkOutput($sformatf("stream t%0d arr_b", t), 64'(bus.arr_b), 64'(eb));
      checkOutput($sformatf("stream t%0d we/busy/done/rdy", t),
                  64'({bus.arr_we, bus.busy, bus.done, bus.in_ready}), 64'(4'b1100));
      drive_garbage(hold_valid);
    end
    @(negedge clk);
    checkOutput("done we/busy/done/rdy",
                64'({bus.arr_we, bus.busy, bus.done, bus.in_ready}), 64'(4'b0110));
    checkOutput("done arr_a|arr_b", 64'({bus.arr_a, bus.arr_b}), 64'(0));
    drive_garbage(hold_valid);
  endtask

  // Replays the captured streams through an ideal systolic array and compares with A x B.
  task automatic checkProducts(input bit has_corner, input logic [31:0] exp_c33);
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] ref_c;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc   = '0;
        ref_c = '0;
        for (int tau = 0; tau < T_STREAM; tau++) begin
          if (tau - j >= 0 && tau - i >= 0) begin
            acc = acc + ACC_WIDTH'(seen_a[tau-j][i*DW +: DW]) * ACC_WIDTH'(seen_b[tau-i][j*DW +: DW]);
          end
        end
        for (int k = 0; k < N; k++) begin
          ref_c = ref_c + ACC_WIDTH'(mat_a[i][k]) * ACC_WIDTH'(mat_b[k][j]);
        end
        checkOutput($sformatf("C[%0d][%0d]", i, j), 64'(acc), 64'(ref_c));
        if (has_corner && i == N - 1 && j == N - 1) begin
          checkOutput("C[3][3] constant", 64'(acc), 64'(exp_c33));
        end
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int budget;
    budget = 0;
    while (bus.in_ready !== 1'b1 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    checkOutput(name, 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    int cycles;

    vecs[0] = '{0, 1'b0, 1'b0, 4, 1'b1, 32'd16};
    vecs[1] = '{1, 1'b1, 1'b0, 7, 1'b1, 32'd24};
    vecs[2] = '{2, 1'b0, 1'b1, 4, 1'b1, 32'd260100};
    vecs[3] = '{3, 1'b1, 1'b1, 7, 1'b0, 32'd0};
    vecs[4] = '{4, 1'b0, 1'b0, 4, 1'b0, 32'd0};

    bus.in_valid = 1'b0;
    bus.in_a_col = '0;
    bus.in_b_row = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset outputs", 64'({bus.arr_we, bus.busy, bus.done, bus.in_ready}), 64'(0));
    checkOutput("reset arr_a|arr_b", 64'({bus.arr_a, bus.arr_b}), 64'(0));
    rst_n = 1'b1;
    wait_ready("in_ready after reset");

    foreach (vecs[v]) begin
      fill_tile(vecs[v].tile_kind);
      applyStimulus(vecs[v].toggle, cycles);
      checkOutput($sformatf("vec%0d load cycles", v), 64'(cycles), 64'(vecs[v].exp_load_cycles));
      runStream(vecs[v].hold_valid);
      checkProducts(vecs[v].has_corner, vecs[v].exp_c33);
    end

    $display("[TB] reset during stream");
    bus.in_valid = 1'b0;
    @(negedge clk);
    fill_tile(5);
    applyStimulus(1'b0, cycles);
    repeat (5) @(negedge clk);
    checkOutput("busy before reset", 64'(bus.busy), 64'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("async reset ctrl", 64'({bus.arr_we, bus.busy, bus.done, bus.in_ready}), 64'(0));
    checkOutput("async reset data", 64'({bus.arr_a, bus.arr_b}), 64'(0));
    drive_garbage(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    wait_ready("in_ready after mid-stream reset");

    fill_tile(6);
    applyStimulus(1'b0, cycles);
    checkOutput("fresh tile load cycles", 64'(cycles), 64'(4));
    runStream(1'b0);
    checkProducts(1'b0, 32'd0);

    @(negedge clk);
    checkOutput("idle after final tile", 64'({bus.arr_we, bus.busy, bus.done, bus.in_ready}), 64'(4'b0001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
